// File: rtl/pc_unit_if.sv
// Request/response bundle between the decode/execute control and pc_unit.
// Requests come from the control side; the fetch PC and status flags are returned.
interface pc_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  stall;
  logic                  br_taken;
  logic [15:0]           br_imm;
  logic                  jmp;
  logic [25:0]           jmp_target;
  logic                  jr;
  logic [ADDR_WIDTH-1:0] jr_addr;
  logic                  exc;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  redirect_pending;
  logic                  misaligned;

  modport master (
    output stall, br_taken, br_imm, jmp, jmp_target, jr, jr_addr, exc,
    input  pc, pc_plus4, redirect_pending, misaligned
  );
  modport slave (
    input  stall, br_taken, br_imm, jmp, jmp_target, jr, jr_addr, exc,
    output pc, pc_plus4, redirect_pending, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with next-PC select and a one-entry redirect buffer for stalls.
// Define PC_UNIT_DELAY_SLOT_EN to give br/jmp/jr a MIPS branch delay slot.
module pc_unit #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] RST_V = AW'(RESET_PC);
  localparam logic [AW-1:0] EXC_V = AW'(EXC_VECTOR);

  logic [AW-1:0] pc, pc_plus4, pend_tgt, tgt_n, pc_n, sel_tgt;
  logic [AW-1:0] br_tgt, jmp_tgt, jr_tgt;
  logic          pend, pend_n, pend_exc, exc_n, mis, mis_n, req, jr_acc;
`ifdef PC_UNIT_DELAY_SLOT_EN
  logic          pend_slot, slot_n;
`endif

  assign pc_plus4 = pc + AW'(4);
  assign br_tgt   = pc_plus4 + {{(AW-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign jmp_tgt  = {pc_plus4[AW-1:28], bus.jmp_target, 2'b00};
  assign jr_tgt   = {bus.jr_addr[AW-1:2], 2'b00};
  assign req      = bus.exc | bus.jr | bus.jmp | bus.br_taken;

  always_comb begin
    sel_tgt = br_tgt;
    if (bus.exc)      sel_tgt = EXC_V;
    else if (bus.jr)  sel_tgt = jr_tgt;
    else if (bus.jmp) sel_tgt = jmp_tgt;
  end

  always_comb begin
    pc_n   = pc;
    pend_n = pend;
    tgt_n  = pend_tgt;
    exc_n  = pend_exc;
    jr_acc = 1'b0;
`ifndef PC_UNIT_DELAY_SLOT_EN
    if (!bus.stall) begin
      pend_n = 1'b0;
      exc_n  = 1'b0;
      if (req) begin
        pc_n   = sel_tgt;
        jr_acc = bus.jr & ~bus.exc;
      end else if (pend) begin
        pc_n = pend_tgt;
      end else begin
        pc_n = pc_plus4;
      end
    end else if (req && !(pend_exc && !bus.exc)) begin
      // a buffered exception can only be displaced by another exception
      pend_n = 1'b1;
      tgt_n  = sel_tgt;
      exc_n  = bus.exc;
      jr_acc = bus.jr & ~bus.exc;
    end
`else
    slot_n = pend_slot;
    if (!bus.stall) begin
      if (bus.exc) begin
        pc_n = EXC_V; pend_n = 1'b0; exc_n = 1'b0; slot_n = 1'b0;
      end else if (pend && (pend_slot || pend_exc)) begin
        pc_n = pend_tgt; pend_n = 1'b0; exc_n = 1'b0; slot_n = 1'b0;
      end else if (pend) begin
        // a branch buffered during a stall still executes its slot first
        pc_n   = pc_plus4;
        slot_n = 1'b1;
      end else if (req) begin
        pc_n   = pc_plus4;
        pend_n = 1'b1;
        tgt_n  = sel_tgt;
        slot_n = 1'b1;
        jr_acc = bus.jr;
      end else begin
        pc_n = pc_plus4;
      end
    end else if (bus.exc || (req && !(pend && (pend_slot || pend_exc)))) begin
      pend_n = 1'b1;
      tgt_n  = sel_tgt;
      exc_n  = bus.exc;
      slot_n = 1'b0;
      jr_acc = bus.jr & ~bus.exc;
    end
`endif
    mis_n = jr_acc & (|bus.jr_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RST_V;
      pend     <= 1'b0;
      pend_tgt <= '0;
      pend_exc <= 1'b0;
      mis      <= 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
      pend_slot <= 1'b0;
`endif
    end else begin
      pc       <= pc_n;
      pend     <= pend_n;
      pend_tgt <= tgt_n;
      pend_exc <= exc_n;
      mis      <= mis_n;
`ifdef PC_UNIT_DELAY_SLOT_EN
      pend_slot <= slot_n;
`endif
    end
  end

  assign bus.pc               = pc;
  assign bus.pc_plus4         = pc_plus4;
  assign bus.redirect_pending = pend;
  assign bus.misaligned       = mis;
endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit; driver queues expected post-edge state,
// monitor compares it against the DUT after every rising edge.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_WIDTH(32)) bus ();
  pc_unit #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        rp;
    logic        mis;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int step  = 0;

  // staged inputs for the next cycle; cleared after each tick
  logic        n_rst, n_stall, n_br, n_jmp, n_jr, n_exc;
  logic [15:0] n_imm;
  logic [25:0] n_jt;
  logic [31:0] n_ra;

  task automatic clr();
    n_rst = 0; n_stall = 0; n_br = 0; n_jmp = 0; n_jr = 0; n_exc = 0;
    n_imm = '0; n_jt = '0; n_ra = '0;
  endtask

  task automatic tick(input logic [31:0] epc, input logic erp, input logic emis);
    exp_t e;
    @(negedge clk);
    rst = n_rst;
    bus.stall = n_stall; bus.br_taken = n_br; bus.br_imm = n_imm;
    bus.jmp = n_jmp; bus.jmp_target = n_jt; bus.jr = n_jr;
    bus.jr_addr = n_ra; bus.exc = n_exc;
    step++;
    e.step = step; e.pc = epc; e.rp = erp; e.mis = emis;
    q.push_back(e);
    clr();
  endtask

  task automatic chk(input string nm, input int st, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, st, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", e.step, bus.pc, e.pc);
        chk("pc_plus4", e.step, bus.pc_plus4, e.pc + 32'd4);
        chk("redirect_pending", e.step, 32'(bus.redirect_pending), 32'(e.rp));
        chk("misaligned", e.step, 32'(bus.misaligned), 32'(e.mis));
      end
    end
  end

  initial begin : driver
    clr();
    bus.stall = 0; bus.br_taken = 0; bus.br_imm = '0; bus.jmp = 0;
    bus.jmp_target = '0; bus.jr = 0; bus.jr_addr = '0; bus.exc = 0;
`ifndef PC_UNIT_DELAY_SLOT_EN
    n_rst = 1; tick(32'h3000, 0, 0);
    tick(32'h3004, 0, 0);
    tick(32'h3008, 0, 0);
    tick(32'h300C, 0, 0);
    tick(32'h3010, 0, 0);
    n_br = 1; n_imm = 16'hFFFC; tick(32'h3004, 0, 0);
    n_br = 1; n_imm = 16'h0010; tick(32'h3048, 0, 0);
    // jr beats jmp; low bits flag misaligned
    n_jmp = 1; n_jt = 26'h1; n_jr = 1; n_ra = 32'h5002; tick(32'h5000, 0, 1);
    tick(32'h5004, 0, 0);
    n_stall = 1; n_jmp = 1; n_jt = 26'h400; tick(32'h5004, 1, 0);
    n_stall = 1; tick(32'h5004, 1, 0);
    n_stall = 1; tick(32'h5004, 1, 0);
    tick(32'h1000, 0, 0);
    tick(32'h1004, 0, 0);
    // reset during a stall discards a buffered exception
    n_stall = 1; n_exc = 1; n_br = 1; n_imm = 16'h0004; tick(32'h1004, 1, 0);
    n_stall = 1; n_rst = 1; tick(32'h3000, 0, 0);
    tick(32'h3004, 0, 0);
    n_exc = 1; n_jr = 1; n_ra = 32'h5003; tick(32'h4180, 0, 0);
    // later stalled request overwrites a buffered branch
    n_stall = 1; n_br = 1; n_imm = 16'h0001; tick(32'h4180, 1, 0);
    n_stall = 1; n_jmp = 1; n_jt = 26'h800; tick(32'h4180, 1, 0);
    tick(32'h2000, 0, 0);
    // buffered exception survives a later jr; jr not accepted so no misaligned
    n_stall = 1; n_exc = 1; tick(32'h2000, 1, 0);
    n_stall = 1; n_jr = 1; n_ra = 32'h7001; tick(32'h2000, 1, 0);
    tick(32'h4180, 0, 0);
    // new request at release beats the pending target
    n_stall = 1; n_br = 1; n_imm = 16'h0000; tick(32'h4180, 1, 0);
    n_jmp = 1; n_jt = 26'h10; tick(32'h0040, 0, 0);
    tick(32'h0044, 0, 0);
    n_stall = 1; n_jr = 1; n_ra = 32'h8002; tick(32'h0044, 1, 1);
    tick(32'h8000, 0, 0);
    // wrap-around of sequential and branch arithmetic
    n_jr = 1; n_ra = 32'hFFFF_FFFF; tick(32'hFFFF_FFFC, 0, 1);
    tick(32'h0000_0000, 0, 0);
    tick(32'h0000_0004, 0, 0);
    n_br = 1; n_imm = 16'hFFF0; tick(32'hFFFF_FFC8, 0, 0);
`else
    n_rst = 1; tick(32'h3000, 0, 0);
    n_jmp = 1; n_jt = 26'h400; tick(32'h3004, 1, 0);
    n_br = 1; n_imm = 16'h0008; tick(32'h1000, 0, 0);
    tick(32'h1004, 0, 0);
    n_rst = 1; tick(32'h3000, 0, 0);
    n_jmp = 1; n_jt = 26'h400; tick(32'h3004, 1, 0);
    n_exc = 1; tick(32'h4180, 0, 0);
    tick(32'h4184, 0, 0);
    n_jr = 1; n_ra = 32'h6002; tick(32'h4188, 1, 1);
    tick(32'h6000, 0, 0);
`endif
    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
